// File: rtl/mips_pkg.sv
// mips_pkg: shared definitions for the single-cycle MIPS-subset core.
// Holds opcode and funct encodings plus the ALU-operation enum that the
// decoder in mips_main drives into mips_alu.
package mips_pkg;

    // Primary opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;

    // R-type function codes (instr[5:0])
    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_XOR,
        ALU_NOR,
        ALU_SLT,
        ALU_SLTU,
        ALU_SLL,
        ALU_SRL,
        ALU_SRA,
        ALU_LUI,
        ALU_ZERO
    } alu_op_e;

endpackage

// File: rtl/mips_if.sv
// mips_alu_if: operand/result bundle between the decoder and the ALU.
//   a, b   : 32-bit operands (a = rs value, b = rt value or extended imm)
//   shamt  : shift amount applied to b for sll/srl/sra
//   op     : ALU operation
//   result : combinational ALU output
// master = decoder side, slave = ALU side.
interface mips_alu_if;
    import mips_pkg::*;

    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  shamt;
    alu_op_e     op;
    logic [31:0] result;

    modport master (output a, b, shamt, op, input result);
    modport slave  (input a, b, shamt, op, output result);
endinterface

// File: rtl/mips_alu.sv
// mips_alu: purely combinational 32-bit ALU.
//   bus.a, bus.b, bus.shamt, bus.op : operands and operation
//   bus.result                      : result (wraps modulo 2^32)
module mips_alu
    import mips_pkg::*;
(
    mips_alu_if.slave bus
);
    logic signed [31:0] a_s;
    logic signed [31:0] b_s;

    assign a_s = bus.a;
    assign b_s = bus.b;

    always_comb begin
        bus.result = '0;
        case (bus.op)
            ALU_ADD:  bus.result = bus.a + bus.b;
            ALU_SUB:  bus.result = bus.a - bus.b;
            ALU_AND:  bus.result = bus.a & bus.b;
            ALU_OR:   bus.result = bus.a | bus.b;
            ALU_XOR:  bus.result = bus.a ^ bus.b;
            ALU_NOR:  bus.result = ~(bus.a | bus.b);
            ALU_SLT:  bus.result = {31'd0, (a_s < b_s)};
            ALU_SLTU: bus.result = {31'd0, (bus.a < bus.b)};
            ALU_SLL:  bus.result = bus.b << bus.shamt;
            ALU_SRL:  bus.result = bus.b >> bus.shamt;
            ALU_SRA:  bus.result = b_s >>> bus.shamt;
            ALU_LUI:  bus.result = {bus.b[15:0], 16'h0000};
            default:  bus.result = '0;
        endcase
    end
endmodule

// File: rtl/mips_main.sv
// mips_main: single-cycle MIPS-subset core (fetch/decode/execute/writeback
// in one clock).
//   alu_result      : combinational ALU result of the instruction at PC
//   instruction_mem : 256-byte program store, big-endian words, driven externally
//   clk             : clock, all state changes on the rising edge
//   reset           : synchronous active-low reset (clears PC and registers)
module mips_main
    import mips_pkg::*;
(
    output logic [31:0] alu_result,
    input  logic [7:0]  instruction_mem [255:0],
    input  logic        clk,
    input  logic        reset
);
    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic [31:0] regs_q [32];

    logic [7:0]  pc_b;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [15:0] imm;
    logic [25:0] target;

    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [31:0] imm_sext;
    logic [31:0] imm_zext;
    logic [31:0] pc_plus4;
    logic [31:0] br_target;

    logic        wr_en;
    logic [4:0]  wr_addr;
    alu_op_e     alu_op;
    logic [31:0] alu_b;

    mips_alu_if alu_bus ();

    // Only the low byte of PC addresses memory; the 8-bit adds wrap at 256.
    assign pc_b  = pc_q[7:0];
    assign instr = {instruction_mem[pc_b],
                    instruction_mem[pc_b + 8'd1],
                    instruction_mem[pc_b + 8'd2],
                    instruction_mem[pc_b + 8'd3]};

    assign opcode = instr[31:26];
    assign rs     = instr[25:21];
    assign rt     = instr[20:16];
    assign rd     = instr[15:11];
    assign shamt  = instr[10:6];
    assign funct  = instr[5:0];
    assign imm    = instr[15:0];
    assign target = instr[25:0];

    assign rs_val    = (rs == 5'd0) ? 32'd0 : regs_q[rs];
    assign rt_val    = (rt == 5'd0) ? 32'd0 : regs_q[rt];
    assign imm_sext  = {{16{imm[15]}}, imm};
    assign imm_zext  = {16'h0000, imm};
    assign pc_plus4  = pc_q + 32'd4;
    assign br_target = pc_plus4 + {imm_sext[29:0], 2'b00};

    always_comb begin
        alu_op  = ALU_ZERO;
        alu_b   = rt_val;
        wr_en   = 1'b0;
        wr_addr = rd;
        pc_d    = pc_plus4;
        case (opcode)
            OP_RTYPE: begin
                wr_en = 1'b1;
                case (funct)
                    FN_ADD, FN_ADDU: alu_op = ALU_ADD;
                    FN_SUB, FN_SUBU: alu_op = ALU_SUB;
                    FN_AND:          alu_op = ALU_AND;
                    FN_OR:           alu_op = ALU_OR;
                    FN_XOR:          alu_op = ALU_XOR;
                    FN_NOR:          alu_op = ALU_NOR;
                    FN_SLT:          alu_op = ALU_SLT;
                    FN_SLTU:         alu_op = ALU_SLTU;
                    FN_SLL:          alu_op = ALU_SLL;
                    FN_SRL:          alu_op = ALU_SRL;
                    FN_SRA:          alu_op = ALU_SRA;
                    default:         wr_en  = 1'b0;   // unknown funct: NOP
                endcase
            end
            OP_ADDI, OP_ADDIU: begin
                alu_op = ALU_ADD;  alu_b = imm_sext; wr_en = 1'b1; wr_addr = rt;
            end
            OP_SLTI: begin
                alu_op = ALU_SLT;  alu_b = imm_sext; wr_en = 1'b1; wr_addr = rt;
            end
            OP_SLTIU: begin
                alu_op = ALU_SLTU; alu_b = imm_sext; wr_en = 1'b1; wr_addr = rt;
            end
            OP_ANDI: begin
                alu_op = ALU_AND;  alu_b = imm_zext; wr_en = 1'b1; wr_addr = rt;
            end
            OP_ORI: begin
                alu_op = ALU_OR;   alu_b = imm_zext; wr_en = 1'b1; wr_addr = rt;
            end
            OP_XORI: begin
                alu_op = ALU_XOR;  alu_b = imm_zext; wr_en = 1'b1; wr_addr = rt;
            end
            OP_LUI: begin
                alu_op = ALU_LUI;  alu_b = imm_zext; wr_en = 1'b1; wr_addr = rt;
            end
            OP_BEQ: begin
                alu_op = ALU_SUB;
                if (rs_val == rt_val) pc_d = br_target;
            end
            OP_BNE: begin
                alu_op = ALU_SUB;
                if (rs_val != rt_val) pc_d = br_target;
            end
            OP_J: begin
                pc_d = {pc_plus4[31:28], target, 2'b00};
            end
            default: ;
        endcase
    end

    assign alu_bus.a     = rs_val;
    assign alu_bus.b     = alu_b;
    assign alu_bus.shamt = shamt;
    assign alu_bus.op    = alu_op;
    assign alu_result    = alu_bus.result;

    mips_alu u_alu (
        .bus (alu_bus)
    );

    // Reset wins over any writeback or control transfer in the same cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_q <= '0;
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            pc_q <= pc_d;
            if (wr_en && (wr_addr != 5'd0)) begin
                regs_q[wr_addr] <= alu_result;
            end
        end
    end
endmodule

// File: tb/tb_mips_main.sv
module tb_mips_main;
    import mips_pkg::*;

    logic        clk;
    logic        reset;
    logic [31:0] alu_result;
    logic [7:0]  mem [255:0];
    logic [31:0] exp_q [0:31];

    int total = 0;
    int bad   = 0;

    mips_main dut (
        .alu_result      (alu_result),
        .instruction_mem (mem),
        .clk             (clk),
        .reset           (reset)
    );

    mips_alu_if alu_bus ();
    mips_alu u_alu_chk (
        .bus (alu_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [31:0] enc_i(logic [5:0] op, logic [4:0] rs, logic [4:0] rt,
                                          logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] enc_r(logic [4:0] rs, logic [4:0] rt, logic [4:0] rd,
                                          logic [4:0] sh, logic [5:0] fn);
        return {6'h00, rs, rt, rd, sh, fn};
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    endtask

    task automatic put_word(int addr, logic [31:0] w);
        mem[(addr + 0) % 256] = w[31:24];
        mem[(addr + 1) % 256] = w[23:16];
        mem[(addr + 2) % 256] = w[15:8];
        mem[(addr + 3) % 256] = w[7:0];
    endtask

    task automatic put(int idx, logic [31:0] w, logic [31:0] e);
        put_word(idx * 4, w);
        exp_q[idx] = e;
    endtask

    task automatic restart();
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        clear_mem();
        mem[0] = 8'h20; mem[1] = 8'h0A; mem[2] = 8'h00; mem[3] = 8'h0A;
        reset = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        total++;
        if (dut.pc_q !== 32'd0) begin
            bad++; $display("FAIL reset_pc got=%h exp=%h", dut.pc_q, 32'd0);
        end
        for (int r = 1; r < 32; r++) begin
            total++;
            if (dut.regs_q[r] !== 32'd0) begin
                bad++; $display("FAIL reset_reg%0d got=%h exp=%h", r, dut.regs_q[r], 32'd0);
            end
        end
        total++;
        if (alu_result !== 32'h0000000A) begin
            bad++; $display("FAIL first_alu got=%h exp=%h", alu_result, 32'h0000000A);
        end
        reset = 1'b1;
        step();
        total++;
        if (dut.regs_q[10] !== 32'd10) begin
            bad++; $display("FAIL first_r10 got=%h exp=%h", dut.regs_q[10], 32'd10);
        end
        total++;
        if (dut.pc_q !== 32'd4) begin
            bad++; $display("FAIL first_pc got=%h exp=%h", dut.pc_q, 32'd4);
        end
    endtask

    task automatic test_alu_ops();
        clear_mem();
        put(0,  enc_i(OP_ADDI, 0, 1, 16'd5),          32'h00000005);
        put(1,  enc_i(OP_ADDI, 0, 2, 16'hFFFD),       32'hFFFFFFFD);
        put(2,  enc_r(1, 2, 3, 0, FN_ADD),            32'h00000002);
        put(3,  enc_r(2, 1, 4, 0, FN_SLT),            32'h00000001);
        put(4,  enc_r(1, 2, 5, 0, FN_SUB),            32'h00000008);
        put(5,  enc_r(2, 1, 6, 0, FN_SLTU),           32'h00000000);
        put(6,  enc_r(1, 2, 7, 0, FN_AND),            32'h00000005);
        put(7,  enc_r(1, 2, 7, 0, FN_OR),             32'hFFFFFFFD);
        put(8,  enc_r(1, 2, 7, 0, FN_XOR),            32'hFFFFFFF8);
        put(9,  enc_r(1, 2, 7, 0, FN_NOR),            32'h00000002);
        put(10, enc_r(0, 2, 8, 1, FN_SRA),            32'hFFFFFFFE);
        put(11, enc_r(0, 2, 8, 28, FN_SRL),           32'h0000000F);
        put(12, enc_r(0, 1, 8, 4, FN_SLL),            32'h00000050);
        put(13, enc_i(OP_ANDI, 2, 9, 16'hF0F0),       32'h0000F0F0);
        put(14, enc_i(OP_ORI, 1, 9, 16'h8000),        32'h00008005);
        put(15, enc_i(OP_XORI, 1, 9, 16'h000F),       32'h0000000A);
        put(16, enc_i(OP_SLTIU, 1, 9, 16'hFFFF),      32'h00000001);
        put(17, enc_i(OP_SLTI, 2, 9, 16'hFFFC),       32'h00000000);
        put(18, enc_r(2, 2, 9, 0, FN_ADDU),           32'hFFFFFFFA);
        put(19, {6'h3F, 26'h0FFFFFF},                 32'h00000000);
        put(20, enc_r(1, 1, 9, 0, 6'h01),             32'h00000000);
        put(21, enc_r(1, 9, 10, 0, FN_SUBU),          32'h0000000B);
        restart();
        for (int i = 0; i < 22; i++) begin
            total++;
            if (alu_result !== exp_q[i]) begin
                bad++; $display("FAIL alu_step%0d got=%h exp=%h", i, alu_result, exp_q[i]);
            end
            step();
        end
        total++;
        if (dut.regs_q[3] !== 32'h00000002) begin
            bad++; $display("FAIL r3_add got=%h exp=%h", dut.regs_q[3], 32'h2);
        end
        total++;
        if (dut.regs_q[4] !== 32'h00000001) begin
            bad++; $display("FAIL r4_slt got=%h exp=%h", dut.regs_q[4], 32'h1);
        end
        total++;
        if (dut.regs_q[9] !== 32'hFFFFFFFA) begin
            bad++; $display("FAIL nop_keeps_r9 got=%h exp=%h", dut.regs_q[9], 32'hFFFFFFFA);
        end
        total++;
        if (dut.pc_q !== 32'd88) begin
            bad++; $display("FAIL nop_pc got=%h exp=%h", dut.pc_q, 32'd88);
        end
    endtask

    task automatic test_branch();
        logic [31:0] exp_pc [0:5];
        logic [31:0] exp_alu [0:4];
        clear_mem();
        put_word(0,  enc_i(OP_ADDI, 0, 1, 16'd1));
        put_word(4,  enc_i(OP_BEQ, 1, 1, 16'd1));
        put_word(8,  enc_i(OP_ADDI, 0, 2, 16'd7));
        put_word(12, enc_i(OP_ADDI, 0, 3, 16'd9));
        put_word(16, enc_i(OP_BNE, 1, 1, 16'd5));
        put_word(20, enc_i(OP_BNE, 1, 0, 16'd1));
        exp_pc[0] = 0;  exp_pc[1] = 4;  exp_pc[2] = 12;
        exp_pc[3] = 16; exp_pc[4] = 20; exp_pc[5] = 28;
        exp_alu[0] = 1; exp_alu[1] = 0; exp_alu[2] = 9; exp_alu[3] = 0; exp_alu[4] = 1;
        restart();
        for (int i = 0; i < 5; i++) begin
            total++;
            if (dut.pc_q !== exp_pc[i]) begin
                bad++; $display("FAIL br_pc%0d got=%h exp=%h", i, dut.pc_q, exp_pc[i]);
            end
            total++;
            if (alu_result !== exp_alu[i]) begin
                bad++; $display("FAIL br_alu%0d got=%h exp=%h", i, alu_result, exp_alu[i]);
            end
            step();
        end
        total++;
        if (dut.pc_q !== exp_pc[5]) begin
            bad++; $display("FAIL br_pc5 got=%h exp=%h", dut.pc_q, exp_pc[5]);
        end
        total++;
        if (dut.regs_q[2] !== 32'd0) begin
            bad++; $display("FAIL br_skip_r2 got=%h exp=%h", dut.regs_q[2], 32'd0);
        end
        total++;
        if (dut.regs_q[3] !== 32'd9) begin
            bad++; $display("FAIL br_r3 got=%h exp=%h", dut.regs_q[3], 32'd9);
        end
    endtask

    task automatic test_wrap_r0();
        clear_mem();
        put(0, enc_i(OP_LUI, 0, 5, 16'h8000),  32'h80000000);
        put(1, enc_i(OP_ADDI, 5, 6, 16'hFFFF), 32'h7FFFFFFF);
        put(2, enc_i(OP_ADDI, 0, 0, 16'd5),    32'h00000005);
        put(3, enc_r(0, 0, 7, 0, FN_ADD),      32'h00000000);
        restart();
        for (int i = 0; i < 4; i++) begin
            total++;
            if (alu_result !== exp_q[i]) begin
                bad++; $display("FAIL wrap_alu%0d got=%h exp=%h", i, alu_result, exp_q[i]);
            end
            step();
        end
        total++;
        if (dut.regs_q[6] !== 32'h7FFFFFFF) begin
            bad++; $display("FAIL wrap_r6 got=%h exp=%h", dut.regs_q[6], 32'h7FFFFFFF);
        end
    endtask

    task automatic test_jump_wrap();
        clear_mem();
        put_word(0,   {OP_J, 26'h000003F});
        put_word(252, enc_i(OP_ADDI, 0, 11, 16'h0011));
        restart();
        total++;
        if (alu_result !== 32'd0) begin
            bad++; $display("FAIL j_alu got=%h exp=%h", alu_result, 32'd0);
        end
        step();
        total++;
        if (dut.pc_q !== 32'h000000FC) begin
            bad++; $display("FAIL j_pc got=%h exp=%h", dut.pc_q, 32'hFC);
        end
        total++;
        if (alu_result !== 32'h00000011) begin
            bad++; $display("FAIL j_fetch252 got=%h exp=%h", alu_result, 32'h11);
        end
        step();
        total++;
        if (dut.pc_q !== 32'h00000100) begin
            bad++; $display("FAIL wrap_pc got=%h exp=%h", dut.pc_q, 32'h100);
        end
        total++;
        if (alu_result !== 32'd0) begin
            bad++; $display("FAIL wrap_fetch got=%h exp=%h", alu_result, 32'd0);
        end
        total++;
        if (dut.regs_q[11] !== 32'h00000011) begin
            bad++; $display("FAIL wrap_r11 got=%h exp=%h", dut.regs_q[11], 32'h11);
        end
        step();
        total++;
        if (dut.pc_q !== 32'h000000FC) begin
            bad++; $display("FAIL wrap_jpc got=%h exp=%h", dut.pc_q, 32'hFC);
        end
    endtask

    task automatic test_reset_mid();
        clear_mem();
        put_word(0,  enc_i(OP_ADDI, 0, 1, 16'd3));
        put_word(4,  enc_i(OP_ADDI, 1, 2, 16'd4));
        put_word(8,  enc_r(1, 2, 3, 0, FN_ADD));
        put_word(12, enc_i(OP_ADDI, 0, 4, 16'd1));
        restart();
        for (int pass = 0; pass < 2; pass++) begin
            total++;
            if (alu_result !== 32'd3) begin
                bad++; $display("FAIL rm_alu0_p%0d got=%h exp=%h", pass, alu_result, 32'd3);
            end
            step(); step(); step();
            total++;
            if (dut.regs_q[3] !== 32'd10) begin
                bad++; $display("FAIL rm_r3_p%0d got=%h exp=%h", pass, dut.regs_q[3], 32'd10);
            end
            total++;
            if (dut.pc_q !== 32'd12) begin
                bad++; $display("FAIL rm_pc_p%0d got=%h exp=%h", pass, dut.pc_q, 32'd12);
            end
            reset = 1'b0;
            step();
            total++;
            if (dut.pc_q !== 32'd0) begin
                bad++; $display("FAIL rm_rst_pc_p%0d got=%h exp=%h", pass, dut.pc_q, 32'd0);
            end
            for (int r = 1; r < 5; r++) begin
                total++;
                if (dut.regs_q[r] !== 32'd0) begin
                    bad++; $display("FAIL rm_rst_r%0d_p%0d got=%h exp=%h", r, pass, dut.regs_q[r], 32'd0);
                end
            end
            reset = 1'b1;
            #1;
        end
    endtask

    task automatic test_alu_direct();
        alu_bus.a = 32'h80000000; alu_bus.b = 32'h00000001; alu_bus.shamt = 5'd0;
        alu_bus.op = ALU_SLT;
        #1;
        total++;
        if (alu_bus.result !== 32'd1) begin
            bad++; $display("FAIL alu_slt_neg got=%h exp=%h", alu_bus.result, 32'd1);
        end
        alu_bus.op = ALU_SLTU;
        #1;
        total++;
        if (alu_bus.result !== 32'd0) begin
            bad++; $display("FAIL alu_sltu_big got=%h exp=%h", alu_bus.result, 32'd0);
        end
        alu_bus.b = 32'h80000000; alu_bus.shamt = 5'd31; alu_bus.op = ALU_SRA;
        #1;
        total++;
        if (alu_bus.result !== 32'hFFFFFFFF) begin
            bad++; $display("FAIL alu_sra31 got=%h exp=%h", alu_bus.result, 32'hFFFFFFFF);
        end
        alu_bus.op = ALU_ZERO;
        #1;
        total++;
        if (alu_bus.result !== 32'd0) begin
            bad++; $display("FAIL alu_zero got=%h exp=%h", alu_bus.result, 32'd0);
        end
    endtask

    initial begin
        reset = 1'b0;
        clear_mem();
        alu_bus.a = '0; alu_bus.b = '0; alu_bus.shamt = '0; alu_bus.op = ALU_ZERO;
        #1;
        test_reset();
        test_alu_ops();
        test_branch();
        test_wrap_r0();
        test_jump_wrap();
        test_reset_mid();
        test_alu_direct();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
